// File: rtl/rebote_debouncer.sv
// rebote_debouncer: per-key synchronizer and stability-count debouncer producing clean active-high levels
module rebote_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic             F_CLOCK_50,
  input  logic             F_RESET,
  input  logic [WIDTH-1:0] F_BTN_IN,
  output logic [WIDTH-1:0] F_BTN_OUT,
  output logic             F_BUSY
);
  typedef enum logic [1:0] {IDLE_LO, CHECK_HI, IDLE_HI, CHECK_LO} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, busy;
  // normalise polarity so 1 always means pressed, then feed the two-stage synchronizer
  always_comb begin
    sync1_d = (ACTIVE_LOW != 0) ? ~F_BTN_IN : F_BTN_IN;
    sync2_d = sync1_q;
  end
  // synchronizer flops, cleared immediately by reset
  always_ff @(posedge F_CLOCK_50 or posedge F_RESET) begin
    if (F_RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  for (genvar c = 0; c < WIDTH; c++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d, s;
    assign s = sync2_q[c];
    // a CHECK state counts consecutive disagreeing samples; any agreeing sample aborts it
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      case (state_q)
        IDLE_LO: if (s) begin
          state_d = CHECK_HI;
          cnt_d   = CNT_W'(1);
        end
        CHECK_HI: if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_HI;
          out_d   = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
        IDLE_HI: if (!s) begin
          state_d = CHECK_LO;
          cnt_d   = CNT_W'(1);
        end
        CHECK_LO: if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_LO;
          out_d   = 1'b0;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      endcase
    end
    // channel state, counter and debounced level; reset discards everything with no release pulse
    always_ff @(posedge F_CLOCK_50 or posedge F_RESET) begin
      if (F_RESET) begin
        state_q <= IDLE_LO;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end
    assign F_BTN_OUT[c] = out_q;
    assign busy[c]      = (state_q == CHECK_HI) || (state_q == CHECK_LO);
  end
  assign F_BUSY = |busy;
endmodule

// File: tb/tb_rebote_debouncer.sv
// tb_rebote_debouncer: scoreboard bench for the key debouncer
module tb_rebote_debouncer;
  localparam int S = 4;
  typedef struct {int cyc; bit is_busy; int ch; logic val;} ev_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] btn = 4'b1111, btn_hi = 4'b0000;
  logic [3:0] btn_out, out_hi;
  logic busy, busy_hi;
  logic [3:0] exp_out = '0, exp_chk = '0;
  ev_t sb[$];
  int cyc = 0, vectors = 0, errors = 0;

  rebote_debouncer #(.WIDTH(4), .STABLE_CYCLES(S), .CNT_W(20), .ACTIVE_LOW(1)) dut (
    .F_CLOCK_50(clk), .F_RESET(rst), .F_BTN_IN(btn), .F_BTN_OUT(btn_out), .F_BUSY(busy));
  rebote_debouncer #(.WIDTH(4), .STABLE_CYCLES(S), .CNT_W(20), .ACTIVE_LOW(0)) dut_hi (
    .F_CLOCK_50(clk), .F_RESET(rst), .F_BTN_IN(btn_hi), .F_BTN_OUT(out_hi), .F_BUSY(busy_hi));

  always #5 clk = ~clk;

  task automatic sched(int c, bit b, int ch, logic v);
    ev_t e;
    e.cyc = c; e.is_busy = b; e.ch = ch; e.val = v;
    sb.push_back(e);
  endtask

  // raw change captured by sync1 at edge t: check runs from t+2, output settles at t+S+1
  task automatic expect_clean(int ch, int t, logic v);
    sched(t + 2, 1'b1, ch, 1'b1);
    sched(t + S + 1, 1'b0, ch, v);
    sched(t + S + 1, 1'b1, ch, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc == cyc) begin
        if (sb[i].is_busy) exp_chk[sb[i].ch] = sb[i].val;
        else exp_out[sb[i].ch] = sb[i].val;
        sb.delete(i);
      end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (btn_out !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate out=%b busy=%b expected out=0000 busy=0", btn_out, busy);
    end
    for (int t = 0; t < 3; t++) step();
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      step();
      vectors++;
      if (btn_out !== 4'b0000 || busy !== 1'b0 || out_hi !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d out=%b busy=%b out_hi=%b expected all 0", cyc, btn_out, busy, out_hi);
      end
    end
  endtask

  task automatic test_clean();
    int b = cyc;
    for (int t = 1; t <= 40; t++) begin
      if (t == 10) begin btn[0] = 1'b0; expect_clean(0, b + 10, 1'b1); end
      if (t == 30) begin btn[0] = 1'b1; expect_clean(0, b + 30, 1'b0); end
      step();
      vectors++;
      if (btn_out !== exp_out) begin
        errors++;
        $display("FAIL clean_out edge=%0d got=%b expected=%b", t, btn_out, exp_out);
      end
      vectors++;
      if (busy !== |exp_chk) begin
        errors++;
        $display("FAIL clean_busy edge=%0d got=%b expected=%b", t, busy, |exp_chk);
      end
    end
  endtask

  task automatic test_bounce();
    int b = cyc;
    for (int t = 1; t <= 46; t++) begin
      if (t == 12) begin btn[1] = 1'b0; sched(b + 14, 1'b1, 1, 1'b1); end
      if (t == 13) begin btn[1] = 1'b1; sched(b + 15, 1'b1, 1, 1'b0); end
      if (t == 14) begin btn[1] = 1'b0; sched(b + 16, 1'b1, 1, 1'b1); end
      if (t == 15) begin btn[1] = 1'b1; sched(b + 17, 1'b1, 1, 1'b0); end
      if (t == 20) begin btn[1] = 1'b0; expect_clean(1, b + 20, 1'b1); end
      if (t == 30) begin btn[2] = 1'b0; sched(b + 32, 1'b1, 2, 1'b1); end
      if (t == 33) begin btn[2] = 1'b1; sched(b + 35, 1'b1, 2, 1'b0); end
      if (t == 40) begin btn[1] = 1'b1; expect_clean(1, b + 40, 1'b0); end
      step();
      vectors++;
      if (btn_out !== exp_out) begin
        errors++;
        $display("FAIL bounce_out edge=%0d got=%b expected=%b", t, btn_out, exp_out);
      end
      vectors++;
      if (busy !== |exp_chk) begin
        errors++;
        $display("FAIL bounce_busy edge=%0d got=%b expected=%b", t, busy, |exp_chk);
      end
    end
  endtask

  task automatic test_simultaneous();
    int b = cyc;
    for (int t = 1; t <= 70; t++) begin
      if (t == 40) begin btn[3:2] = 2'b00; expect_clean(2, b + 40, 1'b1); expect_clean(3, b + 40, 1'b1); end
      if (t == 50) begin btn[3] = 1'b1; expect_clean(3, b + 50, 1'b0); end
      if (t == 60) begin btn[2] = 1'b1; expect_clean(2, b + 60, 1'b0); end
      step();
      vectors++;
      if (btn_out !== exp_out) begin
        errors++;
        $display("FAIL simul_out edge=%0d got=%b expected=%b", t, btn_out, exp_out);
      end
      vectors++;
      if (busy !== |exp_chk) begin
        errors++;
        $display("FAIL simul_busy edge=%0d got=%b expected=%b", t, busy, |exp_chk);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL simul_pending got=%0d expected=0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int b = cyc;
    btn[0] = 1'b0;
    expect_clean(0, b + 1, 1'b1);
    for (int t = 1; t <= 8; t++) begin
      step();
      vectors++;
      if (btn_out !== exp_out || busy !== |exp_chk) begin
        errors++;
        $display("FAIL midrst_pre edge=%0d out=%b busy=%b expected out=%b busy=%b", t, btn_out, busy, exp_out, |exp_chk);
      end
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (btn_out !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async out=%b busy=%b expected out=0000 busy=0", btn_out, busy);
    end
    #2 rst = 1'b0;
    sb.delete();
    exp_out = '0;
    exp_chk = '0;
    b = cyc;
    expect_clean(0, b + 1, 1'b1);
    for (int t = 1; t <= 18; t++) begin
      if (t == 10) begin btn[0] = 1'b1; expect_clean(0, b + 10, 1'b0); end
      step();
      vectors++;
      if (btn_out !== exp_out) begin
        errors++;
        $display("FAIL midrst_out edge=%0d got=%b expected=%b", t, btn_out, exp_out);
      end
      vectors++;
      if (busy !== |exp_chk) begin
        errors++;
        $display("FAIL midrst_busy edge=%0d got=%b expected=%b", t, busy, |exp_chk);
      end
    end
  endtask

  task automatic test_polarity();
    int b = cyc;
    for (int t = 1; t <= 20; t++) begin
      if (t == 10) btn_hi[0] = 1'b1;
      step();
      vectors++;
      if (out_hi !== {3'b000, (cyc >= b + 15)}) begin
        errors++;
        $display("FAIL polarity edge=%0d got=%b expected=%b", t, out_hi, {3'b000, (cyc >= b + 15)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_polarity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rebote_debouncer.md
# rebote_debouncer

Multi-channel push-button conditioner for the board keys. Each raw, asynchronous, bouncing key line is synchronized to F_CLOCK_50 and converted to a clean, active-high level. The level changes only after the key has held a new value for a programmable number of consecutive clocks. Each F_BTN_OUT bit drives the F_IN of the single-pulse stage that turns one key press into one movement command for the game logic.

## Interface
Parameters:
- WIDTH, 4 — number of independent key channels (up/down/left/right).
- STABLE_CYCLES, 500000 — consecutive clocks a new synchronized value must hold before the output follows (10 ms at 50 MHz); legal range 2 to 2^CNT_W−1.
- CNT_W, 20 — stability counter width per channel.
- ACTIVE_LOW, 1 — 1: raw key reads 0 when pressed (inverted before synchronization); 0: raw key reads 1 when pressed.

Ports:
- F_CLOCK_50  input  1  system clock, 50 MHz.
- F_RESET  input  1  asynchronous, active-high reset.
- F_BTN_IN  input  WIDTH  raw key lines, asynchronous to the clock, bouncing.
- F_BTN_OUT  output  WIDTH  debounced level, 1 = pressed, registered.
- F_BUSY  output  1  OR over all channels of "in a CHECK state", registered.

## Operation
- Polarity: n[i] = F_BTN_IN[i] XOR ACTIVE_LOW, applied combinationally ahead of the synchronizer.
- Synchronizer: two flip-flops per channel, sync1 <= n and sync2 <= sync1. Only sync2 (called s) is used downstream.
- Each channel runs an independent 4-state FSM (IDLE_LO, CHECK_HI, IDLE_HI, CHECK_LO) with its own counter cnt[CNT_W-1:0].
  - IDLE_LO (out=0, cnt=0): if s=1, go to CHECK_HI with cnt=1; else stay.
  - CHECK_HI (out=0): if s=0, go to IDLE_LO with cnt=0. Else, if cnt=STABLE_CYCLES−1, go to IDLE_HI with out=1 and cnt=0. Else cnt+1.
  - IDLE_HI and CHECK_LO are the mirror images, with out returning to 0.
- The output therefore flips on the STABLE_CYCLES-th consecutive edge at which s differs from out. Any single edge where s equals out aborts the check and clears cnt.
- Channels share nothing except the clock, the reset and the F_BUSY OR. Simultaneous activity on several channels is handled independently, with no priority.
- The counter never wraps. It is compared against STABLE_CYCLES−1 and cleared on every exit from a CHECK state.
- F_BUSY = 1 while any channel is in CHECK_HI or CHECK_LO. It is derived from the registered state with no extra register stage.

## Timing
- Reset (asynchronous, immediate): sync1=sync2=0, every FSM in IDLE_LO, cnt=0, F_BTN_OUT=0, F_BUSY=0. This applies equally mid-check or while out=1: all state is discarded and there is no release pulse.
- Latency: if a raw change is first captured by sync1 at edge k and stays stable, F_BTN_OUT changes at edge k+STABLE_CYCLES+1.
- Glitch rejection: a pulse on s lasting STABLE_CYCLES−1 edges or fewer never reaches F_BTN_OUT.
- Key held through reset release: the output rises STABLE_CYCLES+1 edges after the first post-reset edge. Downstream sees a normal press.
- Minimum output pulse width is STABLE_CYCLES edges, because the return path requires the same stability period.
- No combinational path exists from F_BTN_IN to any output.

## Test plan
All scenarios use WIDTH=4, STABLE_CYCLES=4, ACTIVE_LOW=1, with all keys idle at 1111.
- Reset behaviour: assert F_RESET with keys idle → F_BTN_OUT=0000 and F_BUSY=0 immediately; after release they stay 0 for 20 cycles.
- Clean press and release: drive bit0 to 0 just before edge 10 → F_BTN_OUT[0] rises at edge 15 and F_BUSY is 1 from edge 12 to edge 15. Release before edge 30 → F_BTN_OUT[0] falls at edge 35.
- Bounce: on bit1 drive 0,1,0,1 on alternating cycles, then hold 0 from edge 20 → F_BTN_OUT[1] stays 0 until edge 25, then rises. A 3-cycle low pulse on bit2 → F_BTN_OUT[2] never rises.
- Simultaneous channels: bits 2 and 3 go low at the same edge 40 → both outputs rise at edge 45. Bit 3 then releases at edge 50 while bit 2 stays held → only bit 3 falls, at edge 55.
- Reset mid-operation: hold bit0 pressed with F_BTN_OUT[0]=1, pulse F_RESET between edges → output drops to 0 asynchronously. The key is still held, so the output rises again 5 edges after the first post-reset edge.
- Polarity: with ACTIVE_LOW=0, drive bit0=1 at edge 10 → F_BTN_OUT[0]=1 at edge 15.
